// File: rtl/trace_checker_if.sv
// trace_checker_if
//   Groups the character stream, the sampling frequency and the parsed-record
//   results of trace_checker into one bundle.
//
//   Stream contract: there is no valid/ready pair. The feeder presents one
//   character on `char` every clock and the checker consumes it on every
//   rising edge. The checker never stalls. `freq` is held stable while a
//   record is in flight.
//
//   Signals:
//     char        feeder -> checker  ASCII character, always valid
//     freq        feeder -> checker  sampling frequency (power of two, >= 2)
//     format_type checker -> feeder  00 none, 01 register write, 10 memory write
//     error_code  checker -> feeder  [0] time [1] pc [2] addr [3] grf
//     pc_out      checker -> feeder  PC of the last valid record
//     loc_out     checker -> feeder  register index or memory address
//     data_out    checker -> feeder  data of the last valid record
//     state_dbg   checker -> feeder  current parser state, for observation only
interface trace_checker_if #(
    parameter int FREQ_W = 16
);
    logic [7:0]        char;
    logic [FREQ_W-1:0] freq;
    logic [1:0]        format_type;
    logic [3:0]        error_code;
    logic [31:0]       pc_out;
    logic [31:0]       loc_out;
    logic [31:0]       data_out;
    logic [3:0]        state_dbg;

    modport master (
        output char, freq,
        input  format_type, error_code, pc_out, loc_out, data_out, state_dbg
    );

    modport slave (
        input  char, freq,
        output format_type, error_code, pc_out, loc_out, data_out, state_dbg
    );
endinterface

// File: rtl/trace_checker.sv
// trace_checker
//   Byte-serial parser and semantic checker for CPU trace lines of the form
//     ^<time>@<pc>: $<reg> <= <data>#   or   ^<time>@<pc>: *<addr> <= <data>#
//   It classifies each record, latches the parsed fields and flags time, PC,
//   address and register-index errors against the parameter bounds.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     tc     trace_checker_if slave: char/freq in, result fields out
module trace_checker #(
    parameter int          TIME_DIGITS_MAX = 4,
    parameter int          REG_DIGITS_MAX  = 4,
    parameter int          FREQ_W          = 16,
    parameter logic [31:0] PC_LO           = 32'h0000_3000,
    parameter logic [31:0] PC_HI           = 32'h0000_6ffc,
    parameter logic [31:0] ADDR_LO         = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI         = 32'h0000_2ffc,
    parameter int          GRF_MAX         = 31
) (
    input logic              clk,
    input logic              reset,
    trace_checker_if.slave   tc
);
    localparam int TW = 4 * TIME_DIGITS_MAX;
    localparam int RW = 4 * REG_DIGITS_MAX;
    localparam int MW = (TW > FREQ_W) ? TW : FREQ_W;

    typedef enum logic [3:0] {
        S_IDLE, S_TIME, S_PC, S_COLON, S_SP0, S_REG, S_ADDR,
        S_SP1, S_EQ, S_SP2, S_DATA, S_HASH, S_DONE
    } state_t;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_REG  = 2'b01;
    localparam logic [1:0] T_MEM  = 2'b10;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   time_q, time_d;
    logic [RW-1:0]   reg_q, reg_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      type_q, type_d;
    logic [1:0]      ft_q, ft_d;
    logic [3:0]      err_q, err_d;
    logic [31:0]     pc_out_q, pc_out_d;
    logic [31:0]     loc_out_q, loc_out_d;
    logic [31:0]     data_out_q, data_out_d;

    // Bounds are checked through a function so a zero lower bound does not
    // turn into a constant comparison.
    function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v >= lo) && (v <= hi) && (v[1:0] == 2'b00);
    endfunction

    logic [7:0]        c;
    logic              is_dec, is_hex;
    logic [3:0]        nib;
    logic [FREQ_W-1:0] t_mask;
    logic              time_err, pc_err, addr_err, grf_err;

    assign c      = tc.char;
    assign is_dec = (c >= "0") && (c <= "9");
    assign is_hex = is_dec || ((c >= "a") && (c <= "f"));
    // 'a'..'f' have low nibble 1..6, so +9 gives 10..15.
    assign nib    = is_dec ? c[3:0] : c[3:0] + 4'd9;

    // freq is a power of two, so (freq/2 - 1) masks t mod (freq/2).
    assign t_mask   = (tc.freq >> 1) - FREQ_W'(1);
    assign time_err = |(MW'(time_q) & MW'(t_mask));
    assign pc_err   = !in_range(pc_q, PC_LO, PC_HI);
    assign addr_err = (type_q == T_MEM) && !in_range(addr_q, ADDR_LO, ADDR_HI);
    assign grf_err  = (type_q == T_REG) && (32'(reg_q) > 32'(GRF_MAX));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        time_d     = time_q;
        reg_d      = reg_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        type_d     = type_q;
        ft_d       = T_NONE;
        err_d      = 4'b0000;
        pc_out_d   = pc_out_q;
        loc_out_d  = loc_out_q;
        data_out_d = data_out_q;

        if (c == "^") begin
            // A caret restarts parsing from any state, DONE included.
            state_d = S_TIME;
            cnt_d   = 8'd0;
            time_d  = '0;
            reg_d   = '0;
            pc_d    = '0;
            addr_d  = '0;
            data_d  = '0;
            type_d  = T_NONE;
        end else begin
            state_d = S_IDLE;
            unique case (state_q)
                S_TIME: begin
                    if (is_dec && (cnt_q < 8'(TIME_DIGITS_MAX))) begin
                        state_d = S_TIME;
                        time_d  = time_q * TW'(10) + TW'(c[3:0]);
                        cnt_d   = cnt_q + 8'd1;
                    end else if ((c == "@") && (cnt_q != 8'd0)) begin
                        state_d = S_PC;
                        cnt_d   = 8'd0;
                    end
                end
                S_PC: begin
                    if (is_hex) begin
                        pc_d    = {pc_q[27:0], nib};
                        cnt_d   = cnt_q + 8'd1;
                        state_d = (cnt_q == 8'd7) ? S_COLON : S_PC;
                    end
                end
                S_COLON: if (c == ":") state_d = S_SP0;
                S_SP0: begin
                    if (c == " ") begin
                        state_d = S_SP0;
                    end else if (c == "$") begin
                        state_d = S_REG;
                        cnt_d   = 8'd0;
                        type_d  = T_REG;
                    end else if (c == "*") begin
                        state_d = S_ADDR;
                        cnt_d   = 8'd0;
                        type_d  = T_MEM;
                    end
                end
                S_REG: begin
                    if (is_dec && (cnt_q < 8'(REG_DIGITS_MAX))) begin
                        state_d = S_REG;
                        reg_d   = reg_q * RW'(10) + RW'(c[3:0]);
                        cnt_d   = cnt_q + 8'd1;
                    end else if ((c == " ") && (cnt_q != 8'd0)) begin
                        state_d = S_SP1;
                    end else if ((c == "<") && (cnt_q != 8'd0)) begin
                        state_d = S_EQ;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        addr_d  = {addr_q[27:0], nib};
                        cnt_d   = cnt_q + 8'd1;
                        state_d = (cnt_q == 8'd7) ? S_SP1 : S_ADDR;
                    end
                end
                S_SP1: begin
                    if (c == " ")      state_d = S_SP1;
                    else if (c == "<") state_d = S_EQ;
                end
                S_EQ: if (c == "=") state_d = S_SP2;
                S_SP2: begin
                    // The first data digit is taken here, so DATA sees 2..8.
                    if (c == " ") begin
                        state_d = S_SP2;
                    end else if (is_hex) begin
                        state_d = S_DATA;
                        data_d  = {data_q[27:0], nib};
                        cnt_d   = 8'd1;
                    end
                end
                S_DATA: begin
                    if (is_hex) begin
                        data_d  = {data_q[27:0], nib};
                        cnt_d   = cnt_q + 8'd1;
                        state_d = (cnt_q == 8'd7) ? S_HASH : S_DATA;
                    end
                end
                S_HASH: if (c == "#") state_d = S_DONE;
                default: state_d = S_IDLE;   // IDLE and DONE wait for '^'
            endcase
        end

        // Result pulse and field capture happen only on entry to DONE; the
        // accumulators already hold the complete record at that edge.
        if (state_d == S_DONE) begin
            ft_d       = type_q;
            err_d      = {grf_err, addr_err, pc_err, time_err};
            pc_out_d   = pc_q;
            loc_out_d  = (type_q == T_REG) ? 32'(reg_q) : addr_q;
            data_out_d = data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            time_q     <= '0;
            reg_q      <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            type_q     <= T_NONE;
            ft_q       <= T_NONE;
            err_q      <= 4'b0000;
            pc_out_q   <= '0;
            loc_out_q  <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            time_q     <= time_d;
            reg_q      <= reg_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            type_q     <= type_d;
            ft_q       <= ft_d;
            err_q      <= err_d;
            pc_out_q   <= pc_out_d;
            loc_out_q  <= loc_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign tc.format_type = ft_q;
    assign tc.error_code  = err_q;
    assign tc.pc_out      = pc_out_q;
    assign tc.loc_out     = loc_out_q;
    assign tc.data_out    = data_out_q;
    assign tc.state_dbg   = state_q;
endmodule
